// File: rtl/jetpack_physics.sv
// jetpack_physics: vertical-motion engine for the player sprite.
// Optional rebound on ceiling clamp: define JETPACK_CEIL_BOUNCE_EN.
module jetpack_physics #(
    parameter int TICK_W   = 8,
    parameter int TICK_DIV = 256,
    parameter int Y_W      = 9,
    parameter int Y_MIN    = 4,
    parameter int Y_MAX    = 420,
    parameter int Y_START  = 419,
    parameter int V_W      = 5,
    parameter int V_UP_MAX = 6,
    parameter int V_DN_MAX = 8,
    parameter int THRUST   = 2,
    parameter int GRAVITY  = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  thrust_in,
    input  logic [1:0]            game_state,
    output logic [Y_W-1:0]        y_pos,
    output logic signed [V_W-1:0] vel,
    output logic [1:0]            phase,
    output logic                  grounded,
    output logic                  ceil_hit,
    output logic                  step
);

    // Signed working width: wide enough that y + v never wraps.
    localparam int SW = ((Y_W > V_W) ? Y_W : V_W) + 2;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RISING   = 2'd1,
        FALLING  = 2'd2,
        GROUNDED = 2'd3
    } phase_e;

    localparam logic [TICK_W-1:0]    CNT_LAST = TICK_W'(TICK_DIV - 1);
    localparam logic [Y_W-1:0]       Y_START_V = Y_W'(Y_START);
    localparam logic [Y_W-1:0]       Y_MIN_V = Y_W'(Y_MIN);
    localparam logic [Y_W-1:0]       Y_MAX_V = Y_W'(Y_MAX);
    localparam logic signed [SW-1:0] S_THRUST = SW'(THRUST);
    localparam logic signed [SW-1:0] S_GRAV = SW'(GRAVITY);
    localparam logic signed [SW-1:0] S_UP = SW'(-V_UP_MAX);
    localparam logic signed [SW-1:0] S_DN = SW'(V_DN_MAX);
    localparam logic signed [SW-1:0] S_YMIN = SW'(Y_MIN);
    localparam logic signed [SW-1:0] S_YMAX = SW'(Y_MAX);

    phase_e                phase_q, phase_d;
    logic [Y_W-1:0]        y_q, y_d;
    logic signed [V_W-1:0] vel_q, vel_d;
    logic [TICK_W-1:0]     cnt_q, cnt_d;
    logic                  ceil_q, ceil_d;
    logic                  step_q, step_d;

    logic                  run;
    logic                  tick;
    logic signed [SW-1:0]  v_ext;
    logic signed [SW-1:0]  v_nx;
    logic signed [SW-1:0]  y_nx;

    // State register with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            phase_q <= IDLE;
            y_q     <= Y_START_V;
            vel_q   <= '0;
            cnt_q   <= '0;
            ceil_q  <= 1'b0;
            step_q  <= 1'b0;
        end else begin
            phase_q <= phase_d;
            y_q     <= y_d;
            vel_q   <= vel_d;
            cnt_q   <= cnt_d;
            ceil_q  <= ceil_d;
            step_q  <= step_d;
        end
    end

    // Next-state: tick divider, velocity/position integration, clamping.
    always_comb begin
        run  = (game_state == 2'b01);
        tick = (cnt_q == CNT_LAST);

        v_ext = $signed({{(SW - V_W){vel_q[V_W-1]}}, vel_q});
        if (thrust_in) begin
            v_nx = v_ext - S_THRUST;
            if (v_nx < S_UP) v_nx = S_UP;
        end else begin
            v_nx = v_ext + S_GRAV;
            if (v_nx > S_DN) v_nx = S_DN;
        end
        y_nx = $signed({{(SW - Y_W){1'b0}}, y_q}) + v_nx;

        phase_d = phase_q;
        y_d     = y_q;
        vel_d   = vel_q;
        cnt_d   = tick ? '0 : cnt_q + 1'b1;
        ceil_d  = 1'b0;
        step_d  = 1'b0;

        if (!run) begin
            phase_d = IDLE;
            y_d     = Y_START_V;
            vel_d   = '0;
            cnt_d   = '0;
        end else if (phase_q == IDLE) begin
            phase_d = FALLING;
        end else if (tick) begin
            step_d = 1'b1;
            if (y_nx >= S_YMAX) begin
                y_d     = Y_MAX_V;
                vel_d   = '0;
                phase_d = GROUNDED;
            end else if (y_nx <= S_YMIN) begin
                y_d    = Y_MIN_V;
                ceil_d = 1'b1;
`ifdef JETPACK_CEIL_BOUNCE_EN
                vel_d   = V_W'(1);
                phase_d = FALLING;
`else
                vel_d   = '0;
                phase_d = thrust_in ? RISING : FALLING;
`endif
            end else begin
                y_d     = y_nx[Y_W-1:0];
                vel_d   = v_nx[V_W-1:0];
                phase_d = v_nx[SW-1] ? RISING : FALLING;
            end
        end
    end

    // Outputs straight from registered state.
    always_comb begin
        y_pos    = y_q;
        vel      = vel_q;
        phase    = phase_q;
        grounded = (phase_q == GROUNDED);
        ceil_hit = ceil_q;
        step     = step_q;
    end

endmodule

// File: tb/tb_jetpack_physics.sv
// tb_jetpack_physics: directed + randomized bench for jetpack_physics.
// Reference model works on plain integers from the motion rules.
module tb_jetpack_physics;

    localparam int DIV = 4;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              thrust_in = 1'b0;
    logic [1:0]        game_state = 2'b00;
    logic [8:0]        y_pos;
    logic signed [4:0] vel;
    logic [1:0]        phase;
    logic              grounded;
    logic              ceil_hit;
    logic              step;

    int checks = 0;
    int errors = 0;

    int my = 419;
    int mv = 0;
    int mph = 0;
    int mcnt = 0;
    int mceil = 0;
    int mstp = 0;

    jetpack_physics #(.TICK_DIV(DIV)) dut (
        .clk(clk),
        .reset(reset),
        .thrust_in(thrust_in),
        .game_state(game_state),
        .y_pos(y_pos),
        .vel(vel),
        .phase(phase),
        .grounded(grounded),
        .ceil_hit(ceil_hit),
        .step(step)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag,
                       input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One clock edge of the reference: phase 0 idle, 1 rising,
    // 2 falling, 3 grounded; positions and speeds as integers.
    task automatic model();
        int nv;
        int ny;
        mceil = 0;
        mstp = 0;
        if (reset || game_state != 2'b01) begin
            my = 419;
            mv = 0;
            mph = 0;
            mcnt = 0;
        end else if (mph == 0) begin
            mph = 2;
            mcnt = (mcnt + 1) % DIV;
        end else if (mcnt != DIV - 1) begin
            mcnt = mcnt + 1;
        end else begin
            mcnt = 0;
            mstp = 1;
            if (thrust_in) nv = (mv - 2 < -6) ? -6 : mv - 2;
            else nv = (mv + 1 > 8) ? 8 : mv + 1;
            ny = my + nv;
            if (ny >= 420) begin
                my = 420;
                mv = 0;
                mph = 3;
            end else if (ny <= 4) begin
                my = 4;
                mceil = 1;
`ifdef JETPACK_CEIL_BOUNCE_EN
                mv = 1;
                mph = 2;
`else
                mv = 0;
                mph = thrust_in ? 1 : 2;
`endif
            end else begin
                my = ny;
                mv = nv;
                mph = (nv < 0) ? 1 : 2;
            end
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        model();
        #1;
        chk("y_pos", y_pos, my);
        chk("vel", vel, mv);
        chk("phase", phase, mph);
        chk("grounded", grounded, mph == 3);
        chk("ceil_hit", ceil_hit, mceil);
        chk("step", step, mstp);
    endtask

    initial begin
        // Reset state.
        repeat (2) cyc();
        chk("rst_y", y_pos, 419);
        chk("rst_phase", phase, 0);

        // First run: falls one row onto the floor.
        reset = 1'b0;
        game_state = 2'b01;
        thrust_in = 1'b0;
        repeat (4) cyc();
        chk("floor_y", y_pos, 420);
        chk("floor_grounded", grounded, 1);
        repeat (8) cyc();

        // Lift off: 418, 414, 408, 402, 396.
        thrust_in = 1'b1;
        repeat (20) cyc();
        chk("climb_y", y_pos, 396);
        chk("climb_vel", vel, -6);

        // Keep thrusting into the ceiling.
        repeat (70 * DIV) cyc();
        chk("ceil_y", y_pos, 4);

        // Free fall to terminal speed.
        thrust_in = 1'b0;
        repeat (15 * DIV) cyc();
        chk("term_vel", vel, 8);

        // Freeze mid-flight, then resume.
        game_state = 2'b10;
        cyc();
        chk("frz_y", y_pos, 419);
        chk("frz_phase", phase, 0);
        game_state = 2'b01;
        thrust_in = 1'b1;
        repeat (4 * DIV) cyc();
        chk("resume_y", y_pos, 401);

        // Release at full upward speed.
        thrust_in = 1'b0;
        repeat (12 * DIV) cyc();

        // Reset with thrust held and RUN active.
        repeat (3) cyc();
        reset = 1'b1;
        thrust_in = 1'b1;
        cyc();
        chk("rst2_y", y_pos, 419);
        chk("rst2_vel", vel, 0);
        reset = 1'b0;

        // Randomized blocks alternating thrust bias.
        for (int blk = 0; blk < 8; blk++) begin
            int p;
            p = (blk % 2 == 1) ? 8 : 3;
            repeat (100) begin
                thrust_in = ($urandom_range(0, 9) < p);
                if ($urandom_range(0, 99) == 0)
                    game_state = 2'($urandom_range(0, 3));
                else
                    game_state = 2'b01;
                reset = ($urandom_range(0, 199) == 0);
                cyc();
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
